// File: rtl/adder_stim_master.sv
// adder_stim_master: self-checking initiator for a registered WIDTH-bit adder.
// On each accepted start it issues NUM_TXN back-to-back operations (counter or
// LFSR operands), compares every returned sum one cycle after capture against an
// internally computed value, and keeps saturating pass/fail counts plus a record
// of the first mismatch.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, mode       burst request and operand source (0 counter, 1 LFSR)
//   enable, a, b      registered drive into the adder
//   sum               adder result (WIDTH+1 bits), valid one cycle after enable
//   busy, done        burst in progress / one-cycle completion pulse
//   pass_cnt, fail_cnt, fail_seen, fail_a, fail_b, fail_sum   burst statistics
module adder_stim_master #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned NUM_TXN   = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic             enable,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH:0]   sum,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pass_cnt,
    output logic [15:0]      fail_cnt,
    output logic             fail_seen,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH:0]   fail_sum
);

    localparam int unsigned OpBits  = 2 * WIDTH;
    localparam logic [15:0] NumTxn  = 16'(NUM_TXN);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    state_e             state_q, state_d;
    logic               mode_q;
    logic [15:0]        k_q;      // index of the next op to issue
    logic [15:0]        lfsr_q;   // LFSR value for the next op
    logic               enable_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH:0]     exp_q;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic               chk_q;
    logic [15:0]        pass_q, fail_q;
    logic               fail_seen_q;
    logic [WIDTH-1:0]   fail_a_q, fail_b_q;
    logic [WIDTH:0]     fail_sum_q;

    logic               accept;
    logic               issue;
    logic [OpBits-1:0]  op_src;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                    issue   = 1'b1;
                end
            end
            StRun: begin
                if (k_q == NumTxn) begin
                    state_d = StDrain;
                end else begin
                    issue = 1'b1;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Op 0 is issued on the accepting edge, so it comes straight from mode/seed.
    always_comb begin
        if (accept) begin
            op_src = mode ? LFSR_SEED[OpBits-1:0] : '0;
        end else begin
            op_src = mode_q ? lfsr_q[OpBits-1:0] : k_q[OpBits-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            k_q         <= '0;
            lfsr_q      <= '0;
            enable_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            exp_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            chk_q       <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
            fail_seen_q <= 1'b0;
            fail_a_q    <= '0;
            fail_b_q    <= '0;
            fail_sum_q  <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= issue;
            if (issue) begin
                a_q <= op_src[OpBits-1:WIDTH];
                b_q <= op_src[WIDTH-1:0];
            end
            if (accept) begin
                mode_q <= mode;
                k_q    <= 16'd1;
                lfsr_q <= lfsr_next(LFSR_SEED);
            end else if (issue) begin
                k_q    <= k_q + 16'd1;
                lfsr_q <= lfsr_next(lfsr_q);
            end

            // Expected value tracks what the adder captures on this same edge.
            chk_q <= enable_q;
            if (enable_q) begin
                exp_q <= {1'b0, a_q} + {1'b0, b_q};
                opa_q <= a_q;
                opb_q <= b_q;
            end

            if (accept) begin
                pass_q      <= '0;
                fail_q      <= '0;
                fail_seen_q <= 1'b0;
                fail_a_q    <= '0;
                fail_b_q    <= '0;
                fail_sum_q  <= '0;
            end else if (chk_q) begin
                if (sum == exp_q) begin
                    if (pass_q != 16'hFFFF) pass_q <= pass_q + 16'd1;
                end else begin
                    if (fail_q != 16'hFFFF) fail_q <= fail_q + 16'd1;
                    if (!fail_seen_q) begin
                        fail_seen_q <= 1'b1;
                        fail_a_q    <= opa_q;
                        fail_b_q    <= opb_q;
                        fail_sum_q  <= sum;
                    end
                end
            end
        end
    end

    assign enable    = enable_q;
    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign fail_seen = fail_seen_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_sum  = fail_sum_q;

endmodule

// File: tb/tb_adder_stim_master.sv
// Bench for adder_stim_master: a small registered adder with a stuck-at-0 fault
// mask, a 16-op instance for the functional/fault/reset scenarios and a 256-op
// instance for the full operand sweep including the carry-out case.
module tb_adder_stim_master;

    localparam int          N     = 16;
    localparam int          NBIG  = 256;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        enable;
    logic [3:0]  a, b;
    logic [4:0]  sum;
    logic        busy, done;
    logic [15:0] pass_cnt, fail_cnt;
    logic        fail_seen;
    logic [3:0]  fail_a, fail_b;
    logic [4:0]  fail_sum;
    logic [4:0]  fault_mask = 5'd0;

    logic        start_big = 1'b0;
    logic        enable_big;
    logic [3:0]  a_big, b_big;
    logic [4:0]  sum_big;
    logic        busy_big, done_big;
    logic [15:0] pass_big, fail_big;
    logic        fail_seen_big;
    logic [3:0]  fail_a_big, fail_b_big;
    logic [4:0]  fail_sum_big;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_stim_master #(.WIDTH(4), .NUM_TXN(N), .LFSR_SEED(SEED)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .enable(enable), .a(a), .b(b),
        .sum(sum), .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .fail_seen(fail_seen), .fail_a(fail_a), .fail_b(fail_b), .fail_sum(fail_sum)
    );

    adder_stim_master #(.WIDTH(4), .NUM_TXN(NBIG), .LFSR_SEED(SEED)) u_big (
        .clk(clk), .rst(rst), .start(start_big), .mode(1'b0), .enable(enable_big),
        .a(a_big), .b(b_big), .sum(sum_big), .busy(busy_big), .done(done_big),
        .pass_cnt(pass_big), .fail_cnt(fail_big), .fail_seen(fail_seen_big),
        .fail_a(fail_a_big), .fail_b(fail_b_big), .fail_sum(fail_sum_big)
    );

    // Registered adders; the small one can have sum bits stuck at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum     <= '0;
            sum_big <= '0;
        end else begin
            if (enable)     sum     <= ({1'b0, a} + {1'b0, b}) & ~fault_mask;
            if (enable_big) sum_big <= {1'b0, a_big} + {1'b0, b_big};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One burst on u_dut, checked op by op against the reference sequence.
    task automatic run_burst(input logic m, input logic [4:0] msk, input bit ign);
        logic [15:0] lq;
        logic [15:0] src;
        logic [3:0]  ea, eb, fa, fb;
        logic [4:0]  good, seen, fsum;
        int          ep, ef;
        bit          fs;
        lq = SEED; ep = 0; ef = 0; fs = 0; fa = 0; fb = 0; fsum = 0;
        fault_mask = msk;
        mode = m;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            src  = m ? lq : 16'(k);
            ea   = src[7:4];
            eb   = src[3:0];
            good = 5'(ea) + 5'(eb);
            seen = good & ~msk;
            if (seen == good) ep++;
            else begin
                ef++;
                if (!fs) begin
                    fs = 1; fa = ea; fb = eb; fsum = seen;
                end
            end
            check_eq("run_enable", enable, 1);
            check_eq("run_busy", busy, 1);
            check_eq("run_done", done, 0);
            check_eq("op_a", a, ea);
            check_eq("op_b", b, eb);
            if (ign && k == 3) start = 1'b1;
            lq = {lq[14:0], ^(lq & 16'hB400)};
            next_cycle();
            start = 1'b0;
        end
        check_eq("drain_enable", enable, 0);
        check_eq("drain_busy", busy, 1);
        check_eq("drain_done", done, 0);
        next_cycle();
        check_eq("done_pulse", done, 1);
        check_eq("done_busy", busy, 0);
        check_eq("pass_cnt", pass_cnt, ep);
        check_eq("fail_cnt", fail_cnt, ef);
        check_eq("fail_seen", fail_seen, fs);
        check_eq("fail_a", fail_a, fa);
        check_eq("fail_b", fail_b, fb);
        check_eq("fail_sum", fail_sum, fsum);
        if (ign) start = 1'b1;
        next_cycle();
        start = 1'b0;
        check_eq("idle_done", done, 0);
        check_eq("idle_enable", enable, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("hold_pass", pass_cnt, ep);
        check_eq("hold_fail", fail_cnt, ef);
        next_cycle();
        check_eq("idle2_enable", enable, 0);
    endtask

    initial begin
        // Reset values
        #1;
        check_eq("rst_enable", enable, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ab", {a, b}, 0);
        check_eq("rst_cnts", {pass_cnt, fail_cnt}, 0);
        check_eq("rst_fail_rec", {fail_seen, fail_a, fail_b, fail_sum}, 0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            check_eq("quiet_enable", enable, 0);
        end

        // Counter mode, LFSR mode, stuck sum[0]
        run_burst(1'b0, 5'd0, 1'b0);
        run_burst(1'b1, 5'd0, 1'b0);
        run_burst(1'b0, 5'b00001, 1'b0);
        check_eq("t4_pass", pass_cnt, 8);
        check_eq("t4_fail", fail_cnt, 8);
        check_eq("t4_rec", {fail_seen, fail_a, fail_b, fail_sum}, {1'b1, 4'h0, 4'h1, 5'h00});

        // Ignored starts in cycle 3 and cycle N+1
        run_burst(1'b1, 5'b00100, 1'b1);

        // Reset in cycle 5 of a burst
        fault_mask = 5'd0;
        mode = 1'b0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 5; i++) next_cycle();
        check_eq("pre_rst_pass", pass_cnt, 4);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_enable", enable, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_cnts", {pass_cnt, fail_cnt}, 0);
        check_eq("mid_rst_done", done, 0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_eq("post_rst_quiet", {done, busy, enable}, 0);
        end
        run_burst(1'b0, 5'd0, 1'b0);

        // Randomized bursts
        for (int t = 0; t < 8; t++) begin
            logic [4:0] msk;
            msk = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'(1 << $urandom_range(0, 4));
            run_burst(1'($urandom_range(0, 1)), msk, 1'($urandom_range(0, 1)));
        end

        // Full 256-op sweep: last op is F+F with carry out
        start_big = 1'b1;
        next_cycle();
        start_big = 1'b0;
        for (int k = 0; k < NBIG; k++) begin
            if (k == 17) check_eq("big_op17", {a_big, b_big}, 8'h11);
            if (k == NBIG - 1) check_eq("big_op255", {a_big, b_big}, 8'hFF);
            next_cycle();
        end
        check_eq("big_drain", {enable_big, busy_big}, 2'b01);
        next_cycle();
        check_eq("big_done", done_big, 1);
        check_eq("big_pass", pass_big, 256);
        check_eq("big_fail", fail_big, 0);
        check_eq("big_seen", fail_seen_big, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
